// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction type encoding and the
// jump-condition function used by the fetch stage and its bench model.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_t;

  // Value of the type bit for each instruction class.
  localparam logic TYPE_A = 1'b0;
  localparam logic TYPE_C = 1'b1;

  // The ROM wait counter only has to hold ROM_LAT-1 for ROM_LAT up to 4.
  localparam int CNT_W = 2;

  // The type bit is always the MSB of the instruction word.
  function automatic int type_bit(input int dw);
    return dw - 1;
  endfunction

  function automatic logic jump_taken(input logic itype, input logic j1,
                                      input logic j2, input logic j3,
                                      input logic zr, input logic ng);
    return (itype == TYPE_C) & ((j1 & ng) | (j2 & zr) | (j3 & ~zr & ~ng));
  endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register: load has priority over increment, otherwise holds.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] load_val,
  output logic [AW-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + AW'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: sequences ROM reads into the IR, then picks the
// next PC from the executing instruction's jump bits and ALU flags.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_RESET | one idle cycle after reset release
// S_FETCH | rom_en high, rom_addr = pc, load ROM wait counter
// S_WAIT  | count down ROM latency, latch rom_data into IR at zero
// S_EXEC  | instr_valid high, next pc chosen at the closing edge
// S_HALT  | idle with pc held until halt drops
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int DW      = 16,
  parameter int AW      = 15,
  parameter int ROM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          halt,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] instr,
  output logic          instr_valid,
  input  logic          cmd_j1,
  input  logic          cmd_j2,
  input  logic          cmd_j3,
  input  logic          alu_zr,
  input  logic          alu_ng,
  input  logic [DW-1:0] a_reg,
  output logic [AW-1:0] pc
);

  localparam int TYPE_POS = type_bit(DW);

  fetch_state_t      state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              exec;
  logic              taken;
  logic              unused_a_hi;

  assign exec     = (state == S_EXEC);
  assign taken    = jump_taken(instr[TYPE_POS], cmd_j1, cmd_j2, cmd_j3, alu_zr, alu_ng);
  assign rom_addr = pc;

  // Jump targets are only AW bits wide; the top of a_reg is dropped.
  assign unused_a_hi = ^a_reg[DW-1:AW];

  pc_reg #(.AW(AW)) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (exec & taken),
    .inc      (exec & ~taken),
    .load_val (a_reg[AW-1:0]),
    .pc       (pc)
  );

  // rom_en and instr_valid are registered: asserted on the edge entering
  // S_FETCH / S_EXEC respectively, so they line up exactly with those states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RESET;
      wait_cnt    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      rom_en      <= 1'b0;
    end else begin
      rom_en      <= 1'b0;
      instr_valid <= 1'b0;
      case (state)
        S_RESET: begin
          state  <= S_FETCH;
          rom_en <= 1'b1;
        end
        S_FETCH: begin
          wait_cnt <= CNT_W'(ROM_LAT - 1);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            instr       <= rom_data;
            instr_valid <= 1'b1;
            state       <= S_EXEC;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_EXEC: begin
          if (halt) begin
            state <= S_HALT;
          end else begin
            state  <= S_FETCH;
            rom_en <= 1'b1;
          end
        end
        S_HALT: begin
          if (!halt) begin
            state  <= S_FETCH;
            rom_en <= 1'b1;
          end
        end
        default: state <= S_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a ROM_LAT=1 instance for the main flow and a
// ROM_LAT=3 instance for the reset-during-read scenario.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n, halt;
  logic        rom_en, instr_valid;
  logic [14:0] rom_addr, pc;
  logic [15:0] rom_data, instr, a_reg;
  logic        cmd_j1, cmd_j2, cmd_j3, alu_zr, alu_ng;

  logic        rst3_n, halt3, zero1;
  logic        rom_en3, instr_valid3;
  logic [14:0] rom_addr3, pc3;
  logic [15:0] rom_data3, instr3, zero16;

  logic [14:0] p1, p3a, p3b, p3c;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch #(.DW(16), .AW(15), .ROM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .instr(instr), .instr_valid(instr_valid),
    .cmd_j1(cmd_j1), .cmd_j2(cmd_j2), .cmd_j3(cmd_j3),
    .alu_zr(alu_zr), .alu_ng(alu_ng), .a_reg(a_reg), .pc(pc)
  );

  instr_fetch #(.DW(16), .AW(15), .ROM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .halt(halt3), .rom_en(rom_en3), .rom_addr(rom_addr3),
    .rom_data(rom_data3), .instr(instr3), .instr_valid(instr_valid3),
    .cmd_j1(zero1), .cmd_j2(zero1), .cmd_j3(zero1),
    .alu_zr(zero1), .alu_ng(zero1), .a_reg(zero16), .pc(pc3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM contents: addr 5 holds JMP, 0x20..0xFF are C-instructions, rest = address.
  function automatic logic [15:0] rom_word(input logic [14:0] a);
    if (a == 15'd5) return 16'hE307;
    else if (a >= 15'h20 && a <= 15'hFF) return 16'hE300;
    else return {1'b0, a};
  endfunction

  // Address pipelines model the ROM latency; they are deliberately not reset.
  always @(posedge clk) begin
    p1  <= rom_addr;
    p3a <= rom_addr3;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign rom_data  = rom_word(p1);
  assign rom_data3 = {1'b0, p3c} + 16'h0100;

  task automatic step_to_exec(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({pc, instr, instr_valid, rom_en} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_vals: pc=%h instr=%h valid=%b rom_en=%b want all 0", pc, instr, instr_valid, rom_en);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (rom_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: rom_en=%b want 0", rom_en);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (rom_en !== 1'b1 || rom_addr !== 15'(k)) begin
        n_fail++;
        $display("FAIL seq_fetch[%0d]: rom_en=%b rom_addr=%h want 1/%h", k, rom_en, rom_addr, k);
      end
      @(negedge clk);
      n_checks++;
      if (rom_en !== 1'b0 || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_wait[%0d]: rom_en=%b valid=%b want 0/0", k, rom_en, instr_valid);
      end
      @(negedge clk);
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== 16'(k)) begin
        n_fail++;
        $display("FAIL seq_exec[%0d]: valid=%b instr=%h want 1/%h", k, instr_valid, instr, k);
      end
    end
  endtask

  task automatic test_jump;
    bit ok;
    step_to_exec(ok);
    step_to_exec(ok);
    n_checks++;
    if (!ok || instr !== 16'hE307 || pc !== 15'd5) begin
      n_fail++;
      $display("FAIL jmp_exec: ok=%b instr=%h pc=%h want 1/e307/0005", ok, instr, pc);
    end
    {cmd_j1, cmd_j2, cmd_j3} = 3'b111; {alu_zr, alu_ng} = 2'b00; a_reg = 16'h0020;
    @(negedge clk);
    n_checks++;
    if (rom_en !== 1'b1 || rom_addr !== 15'h0020) begin
      n_fail++;
      $display("FAIL jmp_taken: rom_en=%b rom_addr=%h want 1/0020", rom_en, rom_addr);
    end
    {cmd_j1, cmd_j2, cmd_j3} = 3'b000;
    step_to_exec(ok);
    {cmd_j1, cmd_j2, cmd_j3} = 3'b111; a_reg = 16'h0005;
    @(negedge clk);
    n_checks++;
    if (rom_addr !== 15'h0005) begin
      n_fail++;
      $display("FAIL jmp_back: rom_addr=%h want 0005", rom_addr);
    end
    step_to_exec(ok);
    {cmd_j1, cmd_j2, cmd_j3} = 3'b000; a_reg = 16'h0020;
    @(negedge clk);
    n_checks++;
    if (rom_en !== 1'b1 || rom_addr !== 15'h0006) begin
      n_fail++;
      $display("FAIL jmp_not_taken: rom_en=%b rom_addr=%h want 1/0006", rom_en, rom_addr);
    end
    step_to_exec(ok);
    {cmd_j1, cmd_j2, cmd_j3} = 3'b111; a_reg = 16'h0040;
    @(negedge clk);
    n_checks++;
    if (rom_addr !== 15'h0007) begin
      n_fail++;
      $display("FAIL a_instr_nojump: instr_at_6 rom_addr=%h want 0007", rom_addr);
    end
    {cmd_j1, cmd_j2, cmd_j3} = 3'b000;
  endtask

  task automatic test_flag_matrix;
    bit ok;
    logic [14:0] cur, exp_next;
    logic [5:0]  mat [11];
    // {j1,j2,j3, zr,ng, taken}
    mat = '{6'b001_00_1, 6'b001_01_0, 6'b001_10_0,
            6'b010_00_0, 6'b010_01_0, 6'b010_10_1,
            6'b100_00_0, 6'b100_01_1, 6'b100_10_0,
            6'b111_11_1, 6'b001_11_0};
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step_to_exec(ok);
      if (!ok || pc == 15'h0020) break;
    end
    n_checks++;
    if (!ok || pc !== 15'h0020) begin
      n_fail++;
      $display("FAIL reach_c_region: ok=%b pc=%h want 1/0020", ok, pc);
    end
    cur = 15'h0020;
    for (int i = 0; i < 11; i++) begin
      {cmd_j1, cmd_j2, cmd_j3} = mat[i][5:3];
      {alu_zr, alu_ng} = mat[i][2:1];
      a_reg = {1'b0, cur + 15'h0010};
      exp_next = mat[i][0] ? cur + 15'h0010 : cur + 15'd1;
      @(negedge clk);
      n_checks++;
      if (rom_en !== 1'b1 || rom_addr !== exp_next) begin
        n_fail++;
        $display("FAIL flag_matrix[%0d]: rom_en=%b rom_addr=%h want 1/%h", i, rom_en, rom_addr, exp_next);
      end
      cur = exp_next;
      {cmd_j1, cmd_j2, cmd_j3} = 3'b000; {alu_zr, alu_ng} = 2'b00;
      step_to_exec(ok);
      n_checks++;
      if (!ok || instr !== 16'hE300) begin
        n_fail++;
        $display("FAIL matrix_exec[%0d]: ok=%b instr=%h want 1/e300", i, ok, instr);
      end
    end
    {cmd_j1, cmd_j2, cmd_j3} = 3'b111; a_reg = 16'hFFFF;
    @(negedge clk);
    n_checks++;
    if (rom_addr !== 15'h7FFF) begin
      n_fail++;
      $display("FAIL jmp_upper_ignored: rom_addr=%h want 7fff", rom_addr);
    end
  endtask

  task automatic test_pc_wrap;
    bit ok;
    {cmd_j1, cmd_j2, cmd_j3} = 3'b000;
    step_to_exec(ok);
    n_checks++;
    if (!ok || instr !== 16'h7FFF || pc !== 15'h7FFF) begin
      n_fail++;
      $display("FAIL wrap_exec: ok=%b instr=%h pc=%h want 1/7fff/7fff", ok, instr, pc);
    end
    {cmd_j1, cmd_j2, cmd_j3} = 3'b111; {alu_zr, alu_ng} = 2'b00; a_reg = 16'h1234;
    @(negedge clk);
    n_checks++;
    if (rom_en !== 1'b1 || rom_addr !== 15'h0000) begin
      n_fail++;
      $display("FAIL pc_wrap: rom_en=%b rom_addr=%h want 1/0000", rom_en, rom_addr);
    end
    {cmd_j1, cmd_j2, cmd_j3} = 3'b000;
  endtask

  task automatic test_halt;
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== 16'h0000 || pc !== 15'h0000) begin
      n_fail++;
      $display("FAIL halt_completes: valid=%b instr=%h pc=%h want 1/0000/0000", instr_valid, instr, pc);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (rom_en !== 1'b0 || instr_valid !== 1'b0 || pc !== 15'h0001) begin
        n_fail++;
        $display("FAIL halt_idle[%0d]: rom_en=%b valid=%b pc=%h want 0/0/0001", k, rom_en, instr_valid, pc);
      end
    end
    halt = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rom_en !== 1'b1 || rom_addr !== 15'h0001) begin
      n_fail++;
      $display("FAIL halt_resume: rom_en=%b rom_addr=%h want 1/0001", rom_en, rom_addr);
    end
  endtask

  task automatic test_reset_mid_wait;
    @(negedge clk);
    rst3_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rom_en3 !== 1'b1 || rom_addr3 !== 15'h0000) begin
      n_fail++;
      $display("FAIL lat3_first_fetch: rom_en=%b rom_addr=%h want 1/0000", rom_en3, rom_addr3);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (instr_valid3 !== 1'b1 || instr3 !== 16'h0100) begin
      n_fail++;
      $display("FAIL lat3_exec0: valid=%b instr=%h want 1/0100", instr_valid3, instr3);
    end
    @(negedge clk);
    n_checks++;
    if (rom_en3 !== 1'b1 || rom_addr3 !== 15'h0001) begin
      n_fail++;
      $display("FAIL lat3_period: rom_en=%b rom_addr=%h want 1/0001", rom_en3, rom_addr3);
    end
    @(negedge clk);
    rst3_n = 1'b0;
    #1;
    n_checks++;
    if ({pc3, instr3, instr_valid3, rom_en3} !== 33'd0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h instr=%h valid=%b rom_en=%b want all 0", pc3, instr3, instr_valid3, rom_en3);
    end
    @(negedge clk);
    rst3_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rom_en3 !== 1'b1 || rom_addr3 !== 15'h0000) begin
      n_fail++;
      $display("FAIL restart_fetch: rom_en=%b rom_addr=%h want 1/0000", rom_en3, rom_addr3);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (instr3 !== 16'h0000 || instr_valid3 !== 1'b0) begin
        n_fail++;
        $display("FAIL stale_not_latched[%0d]: instr=%h valid=%b want 0000/0", k, instr3, instr_valid3);
      end
    end
    @(negedge clk);
    n_checks++;
    if (instr_valid3 !== 1'b1 || instr3 !== 16'h0100) begin
      n_fail++;
      $display("FAIL restart_exec: valid=%b instr=%h want 1/0100", instr_valid3, instr3);
    end
  endtask

  initial begin
    rst_n = 1'b0; rst3_n = 1'b0; halt = 1'b0; halt3 = 1'b0;
    zero1 = 1'b0; zero16 = 16'h0000;
    {cmd_j1, cmd_j2, cmd_j3} = 3'b000; {alu_zr, alu_ng} = 2'b00; a_reg = 16'h0000;
    test_reset();
    test_jump();
    test_flag_matrix();
    test_pc_wrap();
    test_halt();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
